// File: rtl/stack_pkg.sv
// Shared types and defaults for the 8-bit stack-machine datapath.
// The opcode encoding is common to the operand stack and the control unit.
package stack_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;

    typedef logic [7:0] word_t;

    typedef enum logic [2:0] {
        PUSH = 3'd0,
        POP  = 3'd1,
        ADD  = 3'd2,
        SUB  = 3'd3,
        AND  = 3'd4,
        NOT  = 3'd5,
        JMP  = 3'd6,
        JZ   = 3'd7
    } opcode_e;

endpackage

// File: rtl/operand_stack.sv
// LIFO operand stack exposing top and next-of-stack combinationally,
// with sticky overflow/underflow flags for depth-limit violations.
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_do_replace;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_nos_idx;
    logic [AW-1:0]    w_wr_idx;

    always_comb begin
        w_empty      = (r_count == '0);
        w_full       = (r_count == FULL_CNT);
        w_do_push    = push & ~pop & ~w_full;
        w_do_pop     = pop & ~push & ~w_empty;
        // Simultaneous push+pop replaces the top entry; only an empty stack faults.
        w_do_replace = push & pop & ~w_empty;
        w_ovf_evt    = push & ~pop & w_full;
        w_unf_evt    = pop & w_empty;
        w_top_idx    = r_count[AW-1:0] - AW'(1);
        w_nos_idx    = r_count[AW-1:0] - AW'(2);
        w_wr_idx     = w_do_replace ? w_top_idx : r_count[AW-1:0];
    end

    // NOTE: the storage array has no reset; count gating below hides stale
    // entries, so resetting it would only add cost.
    always_ff @(posedge clk) begin
        if (!rst && (w_do_push || w_do_replace)) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // process sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            // A new event wins over a same-cycle clear.
            r_overflow  <= w_ovf_evt | (r_overflow & ~clr_err);
            r_underflow <= w_unf_evt | (r_underflow & ~clr_err);
        end
    end

    always_comb begin
        tos       = w_empty ? '0 : r_mem[w_top_idx];
        nos       = (r_count > CNT_W'(1)) ? r_mem[w_nos_idx] : '0;
        count     = r_count;
        empty     = w_empty;
        full      = w_full;
        overflow  = r_overflow;
        underflow = r_underflow;
    end

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: directed vectors with hand-computed
// snapshots plus a randomized mix checked against a queue reference model.
module tb_operand_stack;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [7:0]       din = '0;
    logic             clr_err = 1'b0;
    logic [7:0]       tos;
    logic [7:0]       nos;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    operand_stack #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
        .clr_err(clr_err), .tos(tos), .nos(nos), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         seq;
        logic [7:0] tos;
        logic [7:0] nos;
        int         cnt;
        logic       ov;
        logic       un;
    } snap_t;

    snap_t exp_q[$];
    snap_t hand_q[$];
    int    total = 0;
    int    bad = 0;
    int    seq = 0;

    // Reference model state
    int   m_stk[$];
    logic m_ov = 1'b0;
    logic m_un = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, seq, act, expv);
        end
    endtask

    task automatic model_update(input logic r, input logic pu, input logic po,
                                input logic [7:0] d, input logic clr);
        logic e_ov = 1'b0;
        logic e_un = 1'b0;
        if (r) begin
            m_stk.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            if (pu && !po) begin
                if (m_stk.size() == DEPTH) e_ov = 1'b1;
                else m_stk.push_back(int'(d));
            end else if (po && !pu) begin
                if (m_stk.size() == 0) e_un = 1'b1;
                else void'(m_stk.pop_back());
            end else if (po && pu) begin
                if (m_stk.size() == 0) e_un = 1'b1;
                else m_stk[m_stk.size()-1] = int'(d);
            end
            m_ov = e_ov | (m_ov & ~clr);
            m_un = e_un | (m_un & ~clr);
        end
    endtask

    // Drive one cycle of inputs, then record the model's expected post-edge state.
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic [7:0] d, input logic clr);
        snap_t s;
        rst = r; push = pu; pop = po; din = d; clr_err = clr;
        @(posedge clk);
        model_update(r, pu, po, d, clr);
        seq++;
        s.seq = seq;
        s.cnt = m_stk.size();
        s.tos = (s.cnt > 0) ? 8'(m_stk[s.cnt-1]) : 8'h00;
        s.nos = (s.cnt > 1) ? 8'(m_stk[s.cnt-2]) : 8'h00;
        s.ov  = m_ov;
        s.un  = m_un;
        exp_q.push_back(s);
        #1;
    endtask

    // Hand-computed snapshot for the step just issued.
    task automatic hand(input logic [7:0] t, input logic [7:0] n, input int c,
                        input logic ov, input logic un);
        snap_t s;
        s.seq = seq; s.tos = t; s.nos = n; s.cnt = c; s.ov = ov; s.un = un;
        hand_q.push_back(s);
    endtask

    // Monitor: the DUT presents a new state every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            check("model.tos", 32'(tos), 32'(e.tos));
            check("model.nos", 32'(nos), 32'(e.nos));
            check("model.count", 32'(count), 32'(e.cnt));
            check("model.empty", 32'(empty), 32'(e.cnt == 0));
            check("model.full", 32'(full), 32'(e.cnt == DEPTH));
            check("model.overflow", 32'(overflow), 32'(e.ov));
            check("model.underflow", 32'(underflow), 32'(e.un));
            if (hand_q.size() > 0 && hand_q[0].seq == e.seq) begin
                snap_t h;
                h = hand_q.pop_front();
                check("hand.tos", 32'(tos), 32'(h.tos));
                check("hand.nos", 32'(nos), 32'(h.nos));
                check("hand.count", 32'(count), 32'(h.cnt));
                check("hand.empty", 32'(empty), 32'(h.cnt == 0));
                check("hand.full", 32'(full), 32'(h.cnt == DEPTH));
                check("hand.overflow", 32'(overflow), 32'(h.ov));
                check("hand.underflow", 32'(underflow), 32'(h.un));
            end
        end
    end

    initial begin
        // Reset state
        step(1, 0, 0, 8'h00, 0);           hand(8'h00, 8'h00, 0, 0, 0);
        // Three pushes
        step(0, 1, 0, 8'h11, 0);
        step(0, 1, 0, 8'h22, 0);
        step(0, 1, 0, 8'h33, 0);           hand(8'h33, 8'h22, 3, 0, 0);

        // Fill to DEPTH, overflow, clear, then replace-top while full
        step(1, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(i), 0);
        hand(8'h08, 8'h07, 8, 0, 0);
        step(0, 1, 0, 8'hFF, 0);           hand(8'h08, 8'h07, 8, 1, 0);
        step(0, 0, 0, 8'h00, 1);           hand(8'h08, 8'h07, 8, 0, 0);
        step(0, 1, 1, 8'h5C, 0);           hand(8'h5C, 8'h07, 8, 0, 0);
        step(0, 1, 0, 8'hEE, 1);           hand(8'h5C, 8'h07, 8, 1, 0);
        step(0, 0, 1, 8'h00, 1);           hand(8'h07, 8'h06, 7, 0, 0);

        // Replace-top at count 2
        step(1, 0, 0, 8'h00, 0);
        step(0, 1, 0, 8'hA0, 0);
        step(0, 1, 0, 8'hB0, 0);           hand(8'hB0, 8'hA0, 2, 0, 0);
        step(0, 1, 1, 8'h5C, 0);           hand(8'h5C, 8'hA0, 2, 0, 0);
        step(0, 0, 1, 8'h00, 0);           hand(8'hA0, 8'h00, 1, 0, 0);
        step(0, 0, 1, 8'h00, 0);           hand(8'h00, 8'h00, 0, 0, 0);

        // Underflow, set-wins over clear, replace-top on empty, then clear
        step(0, 0, 1, 8'h00, 0);           hand(8'h00, 8'h00, 0, 0, 1);
        step(0, 0, 1, 8'h00, 1);           hand(8'h00, 8'h00, 0, 0, 1);
        step(0, 0, 0, 8'h00, 1);           hand(8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 1, 8'h44, 0);           hand(8'h00, 8'h00, 0, 0, 1);
        step(0, 0, 0, 8'h00, 0);           hand(8'h00, 8'h00, 0, 0, 1);

        // Reset wins over a same-cycle push
        step(0, 1, 0, 8'h01, 1);
        step(0, 1, 0, 8'h02, 0);
        step(0, 1, 0, 8'h03, 0);           hand(8'h03, 8'h02, 3, 0, 0);
        step(1, 1, 0, 8'h99, 0);           hand(8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 0, 8'h7E, 0);           hand(8'h7E, 8'h00, 1, 0, 0);

        // Randomized mix against the queue model
        for (int i = 0; i < 2000; i++) begin
            int r;
            logic pu, po, cl, rs;
            r  = int'($urandom_range(0, 99));
            pu = (r < 45) || (r >= 85);
            po = (r >= 45);
            cl = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 249) == 0);
            step(rs, pu, po, 8'($urandom), cl);
        end

        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        check("scoreboard.drained", 32'(exp_q.size() + hand_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- LIFO operand stack for the 8-bit stack-machine datapath.
- Driven by the control FSM's push/pop strobes. Data comes from the memory data register or the ALU result, selected upstream by stack_src.
- Supplies top-of-stack (tos) and next-of-stack (nos) to the datapath A/B operand registers and to the control unit's tos_zero test.
- Detects depth-limit violations and holds them in sticky error flags.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of stack entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- push  input  1  push din onto the stack this cycle.
- pop  input  1  remove the top entry this cycle.
- din  input  WIDTH  data to push.
- clr_err  input  1  clear the sticky error flags.
- tos  output  WIDTH  current top entry; 0 when empty.
- nos  output  WIDTH  entry below the top; 0 when count < 2.
- count  output  CNT_W  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- One clock; reset is synchronous and active-high on rst. Reset has priority over all other inputs in the same cycle.
- Reset values: count = 0, overflow = 0, underflow = 0. Hence tos = 0, nos = 0, empty = 1, full = 0.
- Storage array contents are not reset. tos and nos are forced to 0 by count gating, so stale data is never visible.
- State is the storage array plus the count register (stack pointer = count). All updates happen on the rising edge.
- tos and nos are combinational reads of the array at index count-1 and count-2. The result of an operation is visible on tos in the cycle after the edge that performs it; there is no extra read latency.
- Operations by {push, pop}:
  - 00: hold.
  - 10, not full: mem[count] <= din; count <= count+1.
  - 10, full: no state change; overflow <= 1.
  - 01, not empty: count <= count-1.
  - 01, empty: no state change; underflow <= 1.
  - 11, not empty (replace-top, used by pop-then-push ALU writeback): mem[count-1] <= din; count unchanged. This is not an overflow even when full.
  - 11, empty: no state change; underflow <= 1.
- Error flags:
  - Once set, a flag stays set until clr_err or rst.
  - If clr_err and a new error event occur in the same cycle, the flag ends the cycle set (set wins).
  - clr_err does not affect the array or count.
- Count arithmetic is unsigned CNT_W bits. It never wraps: the full and empty guards above prevent it.
- Array indexing uses the low $clog2(DEPTH) bits. The count == DEPTH case is never used as a write index.
- Inputs are sampled only on the clock edge. Reset asserted mid-sequence discards all content on that edge.

Decomposition:
- stack_pkg holds:
  - WIDTH_DEF = 8 and DEPTH_DEF = 8.
  - The 3-bit opcode enum shared with the control unit: PUSH, POP, ADD, SUB, AND, NOT, JMP, JZ.
  - typedef word_t = logic [7:0].
- No sub-module is required. Array, count register and flag logic fit in one module.
- An optional stack_ptr counter sub-module is acceptable if reused elsewhere.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> after the third edge: tos = 0x33, nos = 0x22, count = 3, empty = 0, full = 0.
- Push 8 values 0x01..0x08, then push 0xFF -> full = 1, count = 8, tos = 0x08, overflow = 1. Then clr_err -> overflow = 0 and tos still 0x08.
- From count = 2 (0xA0, 0xB0), assert push and pop together with din = 0x5C -> count = 2, tos = 0x5C, nos = 0xA0, no flag set. Repeat while full -> count stays 8, overflow stays 0.
- Pop on empty -> underflow = 1, count = 0, tos = 0. Assert clr_err in the same cycle as a second empty pop -> underflow remains 1.
- Push 3 entries, then assert rst together with push -> count = 0, tos = 0, nos = 0, flags 0. Next push 0x7E -> tos = 0x7E, count = 1.
- Randomized push/pop mix (about 2000 cycles) against a queue reference model -> tos, nos, count and flags match every cycle.
